// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states, latencies and helpers for the MDU.
// Optional: MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops (md_op widens to 4 bits).
package mdu_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

`ifdef MDU_MADD_EN
    localparam int unsigned MD_OP_W = 4;
`else
    localparam int unsigned MD_OP_W = 3;
`endif

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = MD_OP_W'(0),
        MD_MULTU = MD_OP_W'(1),
        MD_DIV   = MD_OP_W'(2),
        MD_DIVU  = MD_OP_W'(3),
        MD_MTHI  = MD_OP_W'(4),
        MD_MTLO  = MD_OP_W'(5)
`ifdef MDU_MADD_EN
        ,
        MD_MADD  = MD_OP_W'(8),
        MD_MADDU = MD_OP_W'(9),
        MD_MSUB  = MD_OP_W'(10),
        MD_MSUBU = MD_OP_W'(11)
`endif
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Ops that occupy the unit for a latency period and commit to HI/LO.
    function automatic logic is_arith_op(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_arith_op = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_arith_op = 1'b1;
`endif
            default: is_arith_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Operand signedness for the multiplier and divider.
    function automatic logic is_signed_op(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_DIV: is_signed_op = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MSUB: is_signed_op = 1'b1;
`endif
            default: is_signed_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E/D-stage request and HI/LO result bundle between pipeline and MDU.
interface mdu_if;
    import mdu_pkg::*;

    logic               start;
    logic [MD_OP_W-1:0] md_op;
    logic [XLEN-1:0]    rs_e;
    logic [XLEN-1:0]    rt_e;
    logic               md_use_d;
    logic               busy;
    logic               stall_req;
    logic [XLEN-1:0]    hi;
    logic [XLEN-1:0]    lo;

    modport master (
        output start, md_op, rs_e, rt_e, md_use_d,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, md_op, rs_e, rt_e, md_use_d,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational product / quotient-remainder datapath for the MDU.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [XLEN-1:0]    rs_e,
    input  logic [XLEN-1:0]    rt_e,
    output hilo_t              result_c,
    output logic               div_by_zero_c
);

    logic            sgn;
    logic [63:0]     a_ext;
    logic [63:0]     b_ext;
    logic [63:0]     prod;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    // Multiply via 64-bit extended operands; low 64 bits are exact for both signednesses.
    // Divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN with zero remainder.
    always_comb begin
        sgn           = is_signed_op(md_op);
        a_ext         = sgn ? {{32{rs_e[31]}}, rs_e} : {32'd0, rs_e};
        b_ext         = sgn ? {{32{rt_e[31]}}, rt_e} : {32'd0, rt_e};
        prod          = a_ext * b_ext;

        div_by_zero_c = is_div_op(md_op) && (rt_e == '0);
        a_neg         = sgn && rs_e[31];
        b_neg         = sgn && rt_e[31];
        a_mag         = a_neg ? (~rs_e + 32'd1) : rs_e;
        b_mag         = b_neg ? (~rt_e + 32'd1) : rt_e;
        divisor       = div_by_zero_c ? 32'd1 : b_mag;
        q_mag         = a_mag / divisor;
        r_mag         = a_mag % divisor;
        quot          = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem           = a_neg ? (~r_mag + 32'd1) : r_mag;

        result_c      = is_div_op(md_op) ? hilo_t'({rem, quot}) : hilo_t'(prod);
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MDU latency counter, IDLE/RUN FSM and HI/LO registers.
// Optional: MDU_MADD_EN enables multiply-accumulate/subtract into {hi,lo} at commit.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave md
);

    state_e     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    hilo_t      hilo_q, hilo_n;
    hilo_t      pend_q, pend_n;
    logic       pend_dbz_q, pend_dbz_n;
    hilo_t      arith_res;
    logic       arith_dbz;
    hilo_t      commit_val;
`ifdef MDU_MADD_EN
    logic [MD_OP_W-1:0] pend_op_q, pend_op_n;
`endif

    mdu_arith u_arith (
        .md_op         (md.md_op),
        .rs_e          (md.rs_e),
        .rt_e          (md.rt_e),
        .result_c      (arith_res),
        .div_by_zero_c (arith_dbz)
    );

    // Value written to {hi,lo} at the end of the busy period.
    always_comb begin
        commit_val = pend_q;
`ifdef MDU_MADD_EN
        case (pend_op_q)
            MD_MADD, MD_MADDU: commit_val = hilo_t'(hilo_q + pend_q);
            MD_MSUB, MD_MSUBU: commit_val = hilo_t'(hilo_q - pend_q);
            default:           commit_val = pend_q;
        endcase
`endif
    end

    // Next-state: accept ops in IDLE, count down in RUN, commit on the last busy cycle.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hilo_n     = hilo_q;
        pend_n     = pend_q;
        pend_dbz_n = pend_dbz_q;
`ifdef MDU_MADD_EN
        pend_op_n  = pend_op_q;
`endif
        case (state)
            IDLE: begin
                if (md.start) begin
                    if (is_arith_op(md.md_op)) begin
                        pend_n     = arith_res;
                        pend_dbz_n = arith_dbz;
                        cnt_n      = is_div_op(md.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_n    = RUN;
`ifdef MDU_MADD_EN
                        pend_op_n  = md.md_op;
`endif
                    end else if (md.md_op == MD_MTHI) begin
                        hilo_n.hi = md.rs_e;
                    end else if (md.md_op == MD_MTLO) begin
                        hilo_n.lo = md.rs_e;
                    end
                end
            end
            RUN: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    if (!pend_dbz_q) begin
                        hilo_n = commit_val;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hilo_q     <= '0;
            pend_q     <= '0;
            pend_dbz_q <= 1'b0;
`ifdef MDU_MADD_EN
            pend_op_q  <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hilo_q     <= hilo_n;
            pend_q     <= pend_n;
            pend_dbz_q <= pend_dbz_n;
`ifdef MDU_MADD_EN
            pend_op_q  <= pend_op_n;
`endif
        end
    end

    assign md.busy      = (state == RUN);
    assign md.hi        = hilo_q.hi;
    assign md.lo        = hilo_q.lo;
    // D-stage MDU users wait while the unit is busy or being started this cycle.
    assign md.stall_req = reset & md.md_use_d & (md.busy | md.start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a behavioural model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu_if md_if ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural result of an op given current {hi,lo}; lat = busy cycles (0 = immediate).
    function automatic logic [63:0] ref_model(input logic [MD_OP_W-1:0] op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] cur, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib, q, r;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = int'(a);
        ib = int'(b);
        lat = 0;
        ref_model = cur;
        case (op)
            MD_MULT:  begin lat = MC; ref_model = 64'(sa * sb); end
            MD_MULTU: begin lat = MC; ref_model = 64'(ua * ub); end
            MD_DIV: begin
                lat = DC;
                if (b == 0) ref_model = cur;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = {32'd0, 32'h8000_0000};
                else begin
                    q = ia / ib;
                    r = ia % ib;
                    ref_model = {32'(r), 32'(q)};
                end
            end
            MD_DIVU: begin
                lat = DC;
                if (b == 0) ref_model = cur;
                else ref_model = {a % b, a / b};
            end
            MD_MTHI: ref_model = {a, cur[31:0]};
            MD_MTLO: ref_model = {cur[63:32], a};
`ifdef MDU_MADD_EN
            MD_MADD:  begin lat = MC; ref_model = cur + 64'(sa * sb); end
            MD_MADDU: begin lat = MC; ref_model = cur + 64'(ua * ub); end
            MD_MSUB:  begin lat = MC; ref_model = cur - 64'(sa * sb); end
            MD_MSUBU: begin lat = MC; ref_model = cur - 64'(ua * ub); end
`endif
            default: ref_model = cur;
        endcase
    endfunction

    // Issue one op in the current (idle) cycle and follow it through to its commit cycle.
    task automatic run_op(input logic [MD_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input logic poke);
        logic [63:0] exp;
        int lat;
        exp = ref_model(op, a, b, {hi_m, lo_m}, lat);
        md_if.start    = 1'b1;
        md_if.md_op    = op;
        md_if.rs_e     = a;
        md_if.rt_e     = b;
        md_if.md_use_d = use_d;
        #1;
        checks++;
        if (md_if.busy !== 1'b0 || md_if.stall_req !== use_d) begin
            errors++;
            $display("FAIL accept op=%0d: busy=%b stall_req=%b, required busy=0 stall_req=%b",
                     op, md_if.busy, md_if.stall_req, use_d);
        end
        tick;
        md_if.start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (poke && i == 2) begin
                md_if.start = 1'b1;
                md_if.md_op = MD_MTLO;
                md_if.rs_e  = $urandom;
            end
            #1;
            checks++;
            if (md_if.busy !== 1'b1 || md_if.hi !== hi_m || md_if.lo !== lo_m ||
                md_if.stall_req !== use_d) begin
                errors++;
                $display("FAIL busy op=%0d cyc=%0d: busy=%b hi=%h lo=%h stall=%b, required busy=1 hi=%h lo=%h stall=%b",
                         op, i, md_if.busy, md_if.hi, md_if.lo, md_if.stall_req, hi_m, lo_m, use_d);
            end
            tick;
            md_if.start = 1'b0;
        end
        #1;
        checks++;
        if (md_if.busy !== 1'b0 || md_if.hi !== exp[63:32] || md_if.lo !== exp[31:0] ||
            md_if.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: busy=%b hi=%h lo=%h stall=%b, required busy=0 hi=%h lo=%h stall=0",
                     op, a, b, md_if.busy, md_if.hi, md_if.lo, md_if.stall_req, exp[63:32], exp[31:0]);
        end
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        md_if.md_use_d = 1'b0;
    endtask

    task automatic test_reset;
        reset          = 1'b0;
        md_if.start    = 1'b1;
        md_if.md_op    = MD_MULT;
        md_if.rs_e     = 32'h1234;
        md_if.rt_e     = 32'h5678;
        md_if.md_use_d = 1'b1;
        hi_m = '0;
        lo_m = '0;
        tick;
        tick;
        checks++;
        if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h stall=%b, required all 0",
                     md_if.busy, md_if.hi, md_if.lo, md_if.stall_req);
        end
        md_if.start    = 1'b0;
        md_if.md_use_d = 1'b0;
        reset          = 1'b1;
        tick;
    endtask

    task automatic test_mult;
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        checks++;
        if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const: hi=%h lo=%h, required hi=ffffffff lo=fffffffa", md_if.hi, md_if.lo);
        end
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        checks++;
        if (md_if.hi !== 32'h0000_0002 || md_if.lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL multu_const: hi=%h lo=%h, required hi=00000002 lo=fffffffa", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_div;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checks++;
        if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_const: hi=%h lo=%h, required hi=ffffffff lo=fffffffd", md_if.hi, md_if.lo);
        end
        run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        checks++;
        if (md_if.hi !== 32'd1 || md_if.lo !== 32'd3) begin
            errors++;
            $display("FAIL divu_const: hi=%h lo=%h, required hi=1 lo=3", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_mt;
        run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op(MD_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (md_if.hi !== 32'h1234_5678 || md_if.lo !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mt_const: hi=%h lo=%h, required hi=12345678 lo=9abcdef0", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_div_special;
        run_op(MD_MTLO, 32'h55, 32'd0, 1'b0, 1'b0);
        run_op(MD_DIV, 32'd1000, 32'd0, 1'b0, 1'b0);
        checks++;
        if (md_if.lo !== 32'h55 || md_if.hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL div_zero: hi=%h lo=%h, required hi=12345678 lo=00000055", md_if.hi, md_if.lo);
        end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++;
        if (md_if.lo !== 32'h8000_0000 || md_if.hi !== 32'd0) begin
            errors++;
            $display("FAIL div_ovf: hi=%h lo=%h, required hi=0 lo=80000000", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_stall;
        run_op(MD_MULT, 32'd6, 32'd7, 1'b1, 1'b0);
        checks++;
        if (md_if.lo !== 32'd42) begin
            errors++;
            $display("FAIL stall_mflo: lo=%h, required 0000002a", md_if.lo);
        end
        // Start ignored while busy.
        run_op(MD_MULTU, 32'd9, 32'd9, 1'b1, 1'b1);
        run_op(MD_DIVU, 32'd100, 32'd9, 1'b0, 1'b1);
    endtask

    task automatic test_undefined;
        run_op(MD_OP_W'(6), 32'hDEAD_BEEF, 32'd5, 1'b0, 1'b0);
        run_op(MD_OP_W'(7), 32'hCAFE_F00D, 32'd3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        run_op(MD_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0, 1'b0);
        run_op(MD_MTLO, 32'h55, 32'd0, 1'b0, 1'b0);
        md_if.start = 1'b1;
        md_if.md_op = MD_DIV;
        md_if.rs_e  = 32'd100;
        md_if.rt_e  = 32'd7;
        tick;
        md_if.start = 1'b0;
        tick;
        tick;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h, required all 0", md_if.busy, md_if.hi, md_if.lo);
        end
        tick;
        reset = 1'b1;
        hi_m  = '0;
        lo_m  = '0;
        for (int i = 0; i < 12; i++) begin
            tick;
            checks++;
            if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
                errors++;
                $display("FAIL reset_after cyc=%0d: busy=%b hi=%h lo=%h, required all 0",
                         i, md_if.busy, md_if.hi, md_if.lo);
            end
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        run_op(MD_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
        run_op(MD_MTLO, 32'd10, 32'd0, 1'b0, 1'b0);
        run_op(MD_MADD, 32'd2, 32'd3, 1'b0, 1'b0);
        checks++;
        if (md_if.lo !== 32'd16 || md_if.hi !== 32'd0) begin
            errors++;
            $display("FAIL madd_const: hi=%h lo=%h, required hi=0 lo=10", md_if.hi, md_if.lo);
        end
        run_op(MD_MSUBU, 32'd4, 32'd5, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random;
        logic [MD_OP_W-1:0] op;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            op = MD_OP_W'($urandom_range(0, (1 << MD_OP_W) - 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 16));
                3: a = -32'($urandom_range(1, 100));
                default: ;
            endcase
            run_op(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        md_if.start    = 1'b0;
        md_if.md_op    = MD_MULT;
        md_if.rs_e     = '0;
        md_if.rt_e     = '0;
        md_if.md_use_d = 1'b0;
        test_reset;
        test_mult;
        test_div;
        test_mt;
        test_div_special;
        test_stall;
        test_undefined;
        test_reset_mid_run;
`ifdef MDU_MADD_EN
        test_madd;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline, sitting beside the ALU in the E stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and computes the product or quotient/remainder. It holds the unit busy for a fixed latency, then commits the result to the HI/LO registers. It raises a stall request toward the hazard unit whenever an instruction in D needs the unit while it is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- start  in  1  E-stage instruction is an MDU op; sampled once per cycle
- md_op  in  3  operation code from mdu_pkg, valid when start=1
- rs_e  in  32  forwarded rs value (operand A / MTHI/MTLO source)
- rt_e  in  32  forwarded rt value (operand B)
- md_use_d  in  1  D-stage instruction is any MDU instruction (mult/div/mf/mt)
- busy  out  1  counter running; reset 0
- stall_req  out  1  (busy | start) & md_use_d; combinational; 0 in reset
- hi  out  32  HI register; reset 0
- lo  out  32  LO register; reset 0

## Operation
- States: IDLE, RUN. Reset enters IDLE, counter=0, hi=lo=0, pending result regs=0.
- IDLE, start=1, md_op in {MULT, MULTU, DIV, DIVU}:
  - Latch the full result into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, start=1, md_op=MTHI: hi<=rs_e. For md_op=MTLO: lo<=rs_e. Both are one-cycle writes; busy stays 0.
- RUN: the counter decrements each cycle. On the cycle it equals 1:
  - hi<=pending_hi, lo<=pending_lo.
  - The counter goes to 0 and the state goes to IDLE.
- start while in RUN is ignored. The hazard unit prevents this case via stall_req; the bench checks it is never needed.
- MULT: signed 32x32->64; hi=upper, lo=lower. MULTU: unsigned.
- DIV: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned.
- Divide by zero (rt_e=0): the busy period runs in full, and hi/lo keep their prior values (no commit).
- Undefined md_op with start=1: no state change.

## Timing
- Start accepted in cycle T: busy=1 in cycles T+1..T+N, where N is MULT_CYCLES or DIV_CYCLES.
- New hi/lo are visible from cycle T+N+1, the same cycle busy returns to 0.
- MTHI/MTLO accepted in cycle T: new value visible from T+1.
- Back-to-back: a start in the first cycle with busy=0 is accepted.
- stall_req is asserted in cycle T itself (start=1) so a following mfhi/mflo in D stalls at once. It deasserts in cycle T+N+1.
- Reset low mid-RUN aborts the operation: the pending result is discarded, hi/lo return to 0, and busy drops without waiting for clk.

## Configuration
- MDU_MADD_EN defined: md_op adds MADD, MADDU, MSUB, MSUBU.
  - These use MULT_CYCLES latency.
  - At commit, {hi,lo} <= {hi,lo} ± product. The 64-bit accumulate uses {hi,lo} as of commit time. The product is signed for MADD/MSUB and unsigned for MADDU/MSUBU.
- MDU_MADD_EN undefined: those encodings are undefined ops (no state change). The accumulate adder is not built.

## Structure
- mdu_pkg holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - State encodings IDLE/RUN.
  - Default latency constants.
- One sub-module, mdu_arith: purely combinational; computes the 64-bit {hi,lo} result from md_op, rs_e, rt_e plus a div_by_zero flag. mdu_ctrl owns the counter, the FSM and the registers.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> busy never 1; hi/lo updated one cycle after each.
- DIV with rt=0 after MTLO 0x55 -> busy 10 cycles, lo stays 0x55, hi unchanged. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, md_use_d=1 (mflo in D) -> stall_req high from the start cycle through the last busy cycle. mflo then reads the committed lo.
- reset pulled low at the third busy cycle of a DIV -> busy, hi, lo are 0 immediately. After release no commit occurs. With MDU_MADD_EN: MTLO 10, then MADD 2*3 -> lo=16, hi=0.
